// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_ext_if.sv
// Channel bus between the TPL deframer output, the PN monitor and the
// per-channel register block. The deframer/register side is the master,
// the monitor is the slave.
interface ad_ip_jesd204_tpl_adc_pnmon_ext_if #(
    parameter int W             = 16,
    parameter int ERR_CNT_WIDTH = 32
) ();
    logic                     data_valid;
    logic [W-1:0]             data;
    logic [3:0]               pn_seq_sel;
    logic                     err_cnt_clr;
    logic                     pn_oos;
    logic                     pn_err;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    modport master (
        output data_valid,
        output data,
        output pn_seq_sel,
        output err_cnt_clr,
        input  pn_oos,
        input  pn_err,
        input  err_cnt
    );

    modport slave (
        input  data_valid,
        input  data,
        input  pn_seq_sel,
        input  err_cnt_clr,
        output pn_oos,
        output pn_err,
        output err_cnt
    );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_ext.sv
// Multi-pattern PN monitor for one JESD204 ADC converter channel.
// Checks PN7/PN9/PN15/PN23/PN31 on a W-bit beat, runs a threshold-based
// lock state machine and keeps a saturating error counter.
// Pipeline: stage 1 input register, stage 2 compare + state update,
// then a registered output stage.
module ad_ip_jesd204_tpl_adc_pnmon_ext #(
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int DATA_PATH_WIDTH      = 1,
    parameter int TWOS_COMPLEMENT      = 1,
    parameter int SYNC_THRESHOLD       = 16,
    parameter int OOS_THRESHOLD        = 8,
    parameter int ERR_CNT_WIDTH        = 32
) (
    input logic clk,
    input logic reset,
    ad_ip_jesd204_tpl_adc_pnmon_ext_if.slave bus
);

    localparam int W  = CONVERTER_RESOLUTION * DATA_PATH_WIDTH;
    localparam int HW = (W > 31) ? W : 31;

    localparam logic                     MSB_INV   = (TWOS_COMPLEMENT == 0);
    localparam logic [7:0]               SYNC_LAST = 8'(SYNC_THRESHOLD - 1);
    localparam logic [7:0]               OOS_LAST  = 8'(OOS_THRESHOLD - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX   = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE   = ERR_CNT_WIDTH'(1);

    localparam logic [0:0] ST_OOS    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [3:0] SEL_PN9  = 4'h0;
    localparam logic [3:0] SEL_PN23 = 4'h1;
    localparam logic [3:0] SEL_PN7  = 4'h4;
    localparam logic [3:0] SEL_PN15 = 4'h5;
    localparam logic [3:0] SEL_PN31 = 4'h7;

    // Stage 1 registers
    logic                     r_valid;
    logic [W-1:0]             r_beat;
    logic                     r_clr;

    // Stage 2 registers
    logic [3:0]               r_seqSel;
    logic [0:0]               r_state;
    logic [7:0]               r_matchCnt;
    logic [7:0]               r_mismatchCnt;
    logic [HW-1:0]            r_hist;
    logic                     r_pnErr;
    logic [ERR_CNT_WIDTH-1:0] r_errCnt;

    // Output registers
    logic                     r_oosOut;
    logic                     r_errOut;
    logic [ERR_CNT_WIDTH-1:0] r_errCntOut;

    // Combinational
    logic [W-1:0]             w_swizzled;
    logic [W-1:0]             w_pred;
    logic                     w_supported;
    logic                     w_match;
    logic                     w_nonZero;
    logic                     w_selChange;
    logic                     w_force;
    logic                     w_errEvent;
    logic [HW-1:0]            w_histRx;
    logic [HW-1:0]            w_histPred;

    // Parallel LFSR prediction of the next W bits for x^n + x^t + 1.
    // full = {history, prediction}; bit i of the prediction is the XOR of the
    // bits n and t places older, which always sit at higher indices of full,
    // so walking from the MSB (earliest bit) down resolves every dependency.
    function automatic logic [W-1:0] pnPredict(input logic [HW-1:0] hist,
                                               input int n, input int t);
        logic [HW+W-1:0] full;
        logic            tapN;
        logic            tapT;
        full = {hist, {W{1'b0}}};
        for (int i = W - 1; i >= 0; i--) begin
            tapN    = 1'(full >> (n + i));
            tapT    = 1'(full >> (t + i));
            full[i] = tapN ^ tapT;
        end
        return full[W-1:0];
    endfunction

    // Reorder samples so the earliest one lands in the MSBs and undo offset
    // binary by flipping each sample MSB.
    always_comb begin
        w_swizzled = '0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            w_swizzled[i*CONVERTER_RESOLUTION +: CONVERTER_RESOLUTION] =
                bus.data[(DATA_PATH_WIDTH-1-i)*CONVERTER_RESOLUTION +: CONVERTER_RESOLUTION];
            w_swizzled[i*CONVERTER_RESOLUTION + CONVERTER_RESOLUTION - 1] =
                bus.data[(DATA_PATH_WIDTH-1-i)*CONVERTER_RESOLUTION + CONVERTER_RESOLUTION - 1] ^ MSB_INV;
        end
    end

    // Stage 1: capture the beat, its qualifier and the clear pulse together
    // so a clear lines up with the beat presented alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
            r_clr   <= 1'b0;
        end else begin
            r_valid <= bus.data_valid;
            r_beat  <= w_swizzled;
            r_clr   <= bus.err_cnt_clr;
        end
    end

    // Select the prediction for the registered sequence choice; unsupported
    // codes never match.
    always_comb begin
        w_pred      = '0;
        w_supported = 1'b0;
        case (r_seqSel)
            SEL_PN7: begin
                w_pred      = pnPredict(r_hist, 7, 6);
                w_supported = 1'b1;
            end
            SEL_PN9: begin
                w_pred      = pnPredict(r_hist, 9, 5);
                w_supported = 1'b1;
            end
            SEL_PN15: begin
                w_pred      = pnPredict(r_hist, 15, 14);
                w_supported = 1'b1;
            end
            SEL_PN23: begin
                w_pred      = pnPredict(r_hist, 23, 18);
                w_supported = 1'b1;
            end
            SEL_PN31: begin
                w_pred      = pnPredict(r_hist, 31, 28);
                w_supported = 1'b1;
            end
            default: begin
                w_pred      = '0;
                w_supported = 1'b0;
            end
        endcase
    end

    // Compare result, forced-OOS conditions and the two history update options.
    always_comb begin
        w_match     = w_supported && (r_beat == w_pred);
        w_nonZero   = |r_beat;
        w_selChange = (bus.pn_seq_sel != r_seqSel);
        w_force     = w_selChange || !w_supported;
        w_errEvent  = !w_force && r_valid && (r_state == ST_LOCKED) && !w_match;
        w_histRx    = HW'({r_hist, r_beat});
        w_histPred  = HW'({r_hist, w_pred});
    end

    // Stage 2: lock state machine, run-length counters and history. Out of
    // lock the history follows the received data; in lock it free-runs on
    // the prediction so single errors do not corrupt later comparisons.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seqSel      <= 4'h0;
            r_state       <= ST_OOS;
            r_matchCnt    <= 8'd0;
            r_mismatchCnt <= 8'd0;
            r_hist        <= '0;
            r_pnErr       <= 1'b0;
        end else begin
            r_seqSel <= bus.pn_seq_sel;
            r_pnErr  <= w_errEvent;
            if (w_force) begin
                r_state       <= ST_OOS;
                r_matchCnt    <= 8'd0;
                r_mismatchCnt <= 8'd0;
                if (r_valid) begin
                    r_hist <= w_histRx;
                end
            end else if (r_valid) begin
                if (r_state == ST_OOS) begin
                    r_hist <= w_histRx;
                    if (w_match && w_nonZero) begin
                        if (r_matchCnt == SYNC_LAST) begin
                            r_state       <= ST_LOCKED;
                            r_mismatchCnt <= 8'd0;
                        end
                        r_matchCnt <= r_matchCnt + 8'd1;
                    end else begin
                        r_matchCnt <= 8'd0;
                    end
                end else begin
                    r_hist <= w_histPred;
                    if (!w_match) begin
                        if (r_mismatchCnt == OOS_LAST) begin
                            r_state    <= ST_OOS;
                            r_matchCnt <= 8'd0;
                        end
                        r_mismatchCnt <= r_mismatchCnt + 8'd1;
                    end else begin
                        r_mismatchCnt <= 8'd0;
                    end
                end
            end
        end
    end

    // Saturating error counter; a clear arriving with an error leaves one
    // count so that error is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_errCnt <= '0;
        end else if (r_clr) begin
            r_errCnt <= w_errEvent ? ERR_ONE : '0;
        end else if (w_errEvent && (r_errCnt != ERR_MAX)) begin
            r_errCnt <= r_errCnt + ERR_ONE;
        end
    end

    // Output stage: registered copies of lock status, error pulse and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_oosOut    <= 1'b1;
            r_errOut    <= 1'b0;
            r_errCntOut <= '0;
        end else begin
            r_oosOut    <= (r_state == ST_OOS);
            r_errOut    <= r_pnErr;
            r_errCntOut <= r_errCnt;
        end
    end

    assign bus.pn_oos  = r_oosOut;
    assign bus.pn_err  = r_errOut;
    assign bus.err_cnt = r_errCntOut;

endmodule
